// File: rtl/sat_pkg.sv
// Shared types for the DFS SAT node: FSM states, substitution opcodes, fork record.
// Pure declarations; no logic, latency or backpressure of its own.
package sat_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_EVAL,
        ST_DECIDE,
        ST_BACKTRACK,
        ST_SAT
    } state_t;

    localparam logic SUB_ASSIGN   = 1'b0;
    localparam logic SUB_UNASSIGN = 1'b1;

    // Fork record as exchanged on the ring; vidx is wide enough for any NUM_VARS in use.
    localparam int FORK_VAR_W = 16;
    typedef struct packed {
        logic [FORK_VAR_W-1:0] vidx;
        logic                  val;
    } fork_rec_t;

endpackage

// File: rtl/sat_node_dfs_if.sv
// Node-side bus: fork ring in/out and evaluator substitution/mask channels.
// master = the SAT node, slave = ring neighbour plus evaluator fabric.
interface sat_node_dfs_if #(
    parameter int VAR_W = 8,
    parameter int LITS  = 3
);
    logic             fork_in_valid;
    logic             fork_in_ready;
    logic [VAR_W-1:0] fork_in_var;
    logic             fork_in_val;
    logic             sub_valid;
    logic             sub_ready;
    logic [VAR_W-1:0] sub_var;
    logic             sub_val;
    logic             sub_unassign;
    logic             mask_valid;
    logic [LITS-1:0]  mask;
    logic             fork_out_valid;
    logic             fork_out_ready;
    logic [VAR_W-1:0] fork_out_var;
    logic             fork_out_val;

    modport master (
        input  fork_in_valid, fork_in_var, fork_in_val, sub_ready, mask_valid, mask, fork_out_ready,
        output fork_in_ready, sub_valid, sub_var, sub_val, sub_unassign,
               fork_out_valid, fork_out_var, fork_out_val
    );

    modport slave (
        output fork_in_valid, fork_in_var, fork_in_val, sub_ready, mask_valid, mask, fork_out_ready,
        input  fork_in_ready, sub_valid, sub_var, sub_val, sub_unassign,
               fork_out_valid, fork_out_var, fork_out_val
    );
endinterface

// File: rtl/sat_dfs_stack.sv
// Decision stack of {val, alt_pending} per level with push, pop and top-flip; depth counter.
// Updates land on the next clock edge; no backpressure, caller never pushes past NUM_VARS.
module sat_dfs_stack #(
    parameter int NUM_VARS = 256,
    parameter int VAR_W    = $clog2(NUM_VARS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             push_val_i,
    input  logic             push_alt_i,
    input  logic             pop_i,
    input  logic             flip_i,
    output logic             top_val_o,
    output logic             top_alt_o,
    output logic [VAR_W-1:0] top_idx_o,
    output logic [VAR_W:0]   depth_o
);
    logic [NUM_VARS-1:0] val_q;
    logic [NUM_VARS-1:0] alt_q;
    logic [VAR_W:0]      depth_q, depth_d;
    logic [VAR_W-1:0]    top_q, top_d;

    // top_q tracks depth-1 so the array is never indexed with a borrowed bit
    always_comb begin
        depth_d = depth_q;
        top_d   = top_q;
        if (push_i) begin
            depth_d = depth_q + (VAR_W+1)'(1);
            top_d   = depth_q[VAR_W-1:0];
        end else if (pop_i) begin
            depth_d = depth_q - (VAR_W+1)'(1);
            top_d   = top_q - VAR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
            top_q   <= '0;
        end else begin
            depth_q <= depth_d;
            top_q   <= top_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            val_q[depth_q[VAR_W-1:0]] <= push_val_i;
            alt_q[depth_q[VAR_W-1:0]] <= push_alt_i;
        end else if (flip_i) begin
            val_q[top_q] <= ~val_q[top_q];
            alt_q[top_q] <= 1'b0;
        end
    end

    assign top_val_o = val_q[top_q];
    assign top_alt_o = alt_q[top_q];
    assign top_idx_o = top_q;
    assign depth_o   = depth_q;
endmodule

// File: rtl/sat_node_dfs.sv
// DFS SAT node: decide, evaluate clause masks, backtrack/unassign, offload alternatives to the ring.
// Fork accept -> sub_valid in 1 cycle; sub outputs held until sub_ready, fork_out is a 1-cycle offer.
module sat_node_dfs
    import sat_pkg::*;
#(
    parameter int NUM_VARS    = 256,
    parameter int VAR_W       = $clog2(NUM_VARS),
    parameter int NUM_CLAUSES = 16,
    parameter int LITS        = 3,
    parameter int OFFLOAD_EN  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    sat_node_dfs_if.master     bus,
    output logic               busy,
    output logic               sat_found,
    output logic               unsat_pulse,
    output logic [VAR_W:0]     depth
);
    localparam int CNT_W = $clog2(NUM_CLAUSES + 1);

    state_t           state_q;
    logic [VAR_W-1:0] root_q;
    logic [CNT_W-1:0] cnt_q;
    logic             conflict_q;
    logic             fork_in_ready_q;
    logic             sub_valid_q, sub_val_q, sub_un_q;
    logic [VAR_W-1:0] sub_var_q;
    logic             fo_valid_q;
    logic [VAR_W-1:0] fo_var_q;
    logic             busy_q, sat_q, unsat_q;

    logic             top_val, top_alt;
    logic [VAR_W-1:0] top_idx;
    logic [VAR_W:0]   depth_w;
    logic             accept, offload, push, push_val, push_alt, pop, flip;
    logic [VAR_W-1:0] cur_var, nxt_var;
    logic             hit, last_mask, last_var;

    assign accept    = (state_q == ST_IDLE) && fork_in_ready_q && bus.fork_in_valid;
    assign offload   = (OFFLOAD_EN != 0) && bus.fork_out_ready;
    assign push      = accept || (state_q == ST_DECIDE);
    assign push_val  = accept ? bus.fork_in_val : 1'b0;
    // An offloaded branch belongs to the neighbour, so it is never retried here
    assign push_alt  = accept ? 1'b0 : !offload;
    assign flip      = (state_q == ST_BACKTRACK) && !sub_valid_q && top_alt;
    assign pop       = (state_q == ST_BACKTRACK) && sub_valid_q && bus.sub_ready;
    assign cur_var   = root_q + top_idx;
    assign nxt_var   = cur_var + VAR_W'(1);
    assign hit       = &bus.mask;
    assign last_mask = bus.mask_valid && (cnt_q == CNT_W'(NUM_CLAUSES - 1));
    assign last_var  = ({1'b0, cur_var} == (VAR_W+1)'(NUM_VARS - 1));

    sat_dfs_stack #(.NUM_VARS(NUM_VARS), .VAR_W(VAR_W)) u_stack (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_val_i (push_val),
        .push_alt_i (push_alt),
        .pop_i      (pop),
        .flip_i     (flip),
        .top_val_o  (top_val),
        .top_alt_o  (top_alt),
        .top_idx_o  (top_idx),
        .depth_o    (depth_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            root_q          <= '0;
            cnt_q           <= '0;
            conflict_q      <= 1'b0;
            fork_in_ready_q <= 1'b0;
            sub_valid_q     <= 1'b0;
            sub_var_q       <= '0;
            sub_val_q       <= 1'b0;
            sub_un_q        <= SUB_ASSIGN;
            fo_valid_q      <= 1'b0;
            fo_var_q        <= '0;
            busy_q          <= 1'b0;
            sat_q           <= 1'b0;
            unsat_q         <= 1'b0;
        end else begin
            fo_valid_q <= 1'b0;
            unsat_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    fork_in_ready_q <= 1'b1;
                    if (accept) begin
                        fork_in_ready_q <= 1'b0;
                        root_q          <= bus.fork_in_var;
                        busy_q          <= 1'b1;
                        sub_valid_q     <= 1'b1;
                        sub_var_q       <= bus.fork_in_var;
                        sub_val_q       <= bus.fork_in_val;
                        sub_un_q        <= SUB_ASSIGN;
                        state_q         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.sub_ready) begin
                        sub_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        conflict_q  <= 1'b0;
                        state_q     <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (bus.mask_valid) begin
                        cnt_q      <= cnt_q + CNT_W'(1);
                        conflict_q <= conflict_q | hit;
                    end
                    if (last_mask) begin
                        if (conflict_q || hit) begin
                            state_q <= ST_BACKTRACK;
                        end else if (last_var) begin
                            sat_q   <= 1'b1;
                            state_q <= ST_SAT;
                        end else begin
                            state_q <= ST_DECIDE;
                        end
                    end
                end
                ST_DECIDE: begin
                    fo_valid_q  <= offload;
                    fo_var_q    <= nxt_var;
                    sub_valid_q <= 1'b1;
                    sub_var_q   <= nxt_var;
                    sub_val_q   <= 1'b0;
                    sub_un_q    <= SUB_ASSIGN;
                    state_q     <= ST_ISSUE;
                end
                ST_BACKTRACK: begin
                    if (!sub_valid_q) begin
                        sub_valid_q <= 1'b1;
                        sub_var_q   <= cur_var;
                        if (top_alt) begin
                            // The re-ASSIGN overwrites the old value in the evaluator
                            sub_val_q <= ~top_val;
                            sub_un_q  <= SUB_ASSIGN;
                            state_q   <= ST_ISSUE;
                        end else begin
                            sub_val_q <= 1'b0;
                            sub_un_q  <= SUB_UNASSIGN;
                        end
                    end else if (bus.sub_ready) begin
                        sub_valid_q <= 1'b0;
                        if (depth_w == (VAR_W+1)'(1)) begin
                            unsat_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_SAT: begin
                    state_q <= ST_SAT;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.fork_in_ready  = fork_in_ready_q;
    assign bus.sub_valid      = sub_valid_q;
    assign bus.sub_var        = sub_var_q;
    assign bus.sub_val        = sub_val_q;
    assign bus.sub_unassign   = sub_un_q;
    assign bus.fork_out_valid = fo_valid_q;
    assign bus.fork_out_var   = fo_var_q;
    assign bus.fork_out_val   = fo_valid_q;
    assign busy               = busy_q;
    assign sat_found          = sat_q;
    assign unsat_pulse        = unsat_q;
    assign depth              = depth_w;
endmodule

// File: tb/tb_sat_node_dfs.sv
// Bench for sat_node_dfs with 4 variables, 2 clauses per round and a scripted evaluator.
module tb_sat_node_dfs;
    localparam int NV = 4;
    localparam int VW = 2;
    localparam int NC = 2;
    localparam int LT = 3;

    typedef logic [6:0] rec_t; // {depth, unassign, var, val}

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          busy, sat_found, unsat_pulse;
    logic [VW:0]   depth;

    sat_node_dfs_if #(.VAR_W(VW), .LITS(LT)) bus ();

    sat_node_dfs #(
        .NUM_VARS(NV), .VAR_W(VW), .NUM_CLAUSES(NC), .LITS(LT), .OFFLOAD_EN(1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .sat_found   (sat_found),
        .unsat_pulse (unsat_pulse),
        .depth       (depth)
    );

    always #5 clk = ~clk;

    rec_t       exp_q[$];
    rec_t       obs_q[$];
    int         checks = 0;
    int         failures = 0;
    int         fo_cnt, unsat_cnt, masks_total;
    logic [2:0] fo_last;
    bit         done;

    function automatic rec_t mk(int d, bit un, int v, bit val);
        return {3'(d), un, 2'(v), val};
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.fork_in_valid = 1'b0;
        bus.fork_in_var = '0;
        bus.fork_in_val = 1'b0;
        bus.sub_ready = 1'b0;
        bus.mask_valid = 1'b0;
        bus.mask = '0;
        bus.fork_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic drive_fork(input int v, input bit val);
        for (int i = 0; i < 20 && !bus.fork_in_ready; i++) @(negedge clk);
        bus.fork_in_valid = 1'b1;
        bus.fork_in_var = 2'(v);
        bus.fork_in_val = val;
        @(negedge clk);
        bus.fork_in_valid = 1'b0;
    endtask

    // Evaluator model: accepts each sub, answers ASSIGNs with NC masks; a conflicting
    // (var,val) gets 3'b111 on mask index var%2. A stray mask rides every handshake cycle.
    task automatic serve(input logic [7:0] conf, input int budget);
        int         masks_left, mi, cur_v;
        logic       conf_round, hs;
        logic [2:0] idx;
        masks_left = 0; mi = 0; cur_v = 0; conf_round = 1'b0;
        obs_q.delete();
        fo_cnt = 0; unsat_cnt = 0; masks_total = 0; done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (bus.fork_out_valid) begin
                fo_cnt++;
                fo_last = {bus.fork_out_var, bus.fork_out_val};
            end
            if (unsat_pulse) unsat_cnt++;
            if (sat_found || unsat_pulse) begin
                bus.sub_ready = 1'b0;
                bus.mask_valid = 1'b0;
                done = 1'b1;
                break;
            end
            hs = 1'b0;
            bus.mask_valid = 1'b0;
            bus.mask = 3'b000;
            if (bus.sub_ready) begin
                bus.sub_ready = 1'b0;
            end else if (bus.sub_valid) begin
                obs_q.push_back({depth, bus.sub_unassign, bus.sub_var,
                                 bus.sub_unassign ? 1'b0 : bus.sub_val});
                bus.sub_ready = 1'b1;
                hs = 1'b1;
                bus.mask_valid = 1'b1;
                bus.mask = 3'b111;
                if (!bus.sub_unassign) begin
                    masks_left = NC;
                    mi = 0;
                    cur_v = int'(bus.sub_var);
                    idx = {bus.sub_var, bus.sub_val};
                    conf_round = conf[idx];
                end
            end
            if (!hs && masks_left > 0) begin
                bus.mask_valid = 1'b1;
                bus.mask = (conf_round && mi == cur_v % 2) ? 3'b111 : 3'b000;
                mi++;
                masks_left--;
                masks_total++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [15:0] outs;
        rst_n = 1'b0;
        bus.fork_in_valid = 1'b0;
        bus.sub_ready = 1'b0;
        bus.mask_valid = 1'b0;
        bus.fork_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        outs = {bus.fork_in_ready, bus.sub_valid, bus.sub_var, bus.sub_val, bus.sub_unassign,
                bus.fork_out_valid, bus.fork_out_var, bus.fork_out_val, busy, sat_found,
                unsat_pulse, depth};
        checks++;
        if (outs !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0000", outs);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.fork_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_after_release: got %b expected 1", bus.fork_in_ready);
        end
    endtask

    task automatic test_sat_path();
        apply_reset();
        drive_fork(0, 1'b0);
        checks++;
        if ({bus.sub_valid, bus.sub_unassign, bus.sub_var, bus.sub_val} !== 5'b1_0_00_0) begin
            failures++;
            $display("FAIL fork_to_sub_latency: got %b expected 10000",
                     {bus.sub_valid, bus.sub_unassign, bus.sub_var, bus.sub_val});
        end
        for (int v = 0; v < NV; v++) exp_q.push_back(mk(v + 1, 1'b0, v, 1'b0));
        serve(8'h00, 400);
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL sat_path_timeout: got no end expected sat_found");
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL sat_path_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            rec_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL sat_path_sub: got %b expected %b", o, e);
            end
        end
        exp_q.delete();
        checks++;
        if (masks_total !== 8) begin
            failures++;
            $display("FAIL sat_after_masks: got %0d expected 8", masks_total);
        end
        checks++;
        if (fo_cnt !== 0) begin
            failures++;
            $display("FAIL no_offload_when_busy: got %0d expected 0", fo_cnt);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({sat_found, busy, bus.fork_in_ready, depth} !== 6'b110_100) begin
            failures++;
            $display("FAIL sat_sticky_state: got %b expected 110100",
                     {sat_found, busy, bus.fork_in_ready, depth});
        end
    endtask

    task automatic test_retry();
        apply_reset();
        drive_fork(0, 1'b0);
        exp_q.push_back(mk(1, 1'b0, 0, 1'b0));
        exp_q.push_back(mk(2, 1'b0, 1, 1'b0));
        exp_q.push_back(mk(3, 1'b0, 2, 1'b0));
        exp_q.push_back(mk(3, 1'b0, 2, 1'b1));
        exp_q.push_back(mk(4, 1'b0, 3, 1'b0));
        serve(8'b0001_0000, 400);
        checks++;
        if (!done || obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL retry_count: got %0d done=%0d expected %0d done=1",
                     obs_q.size(), done, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            rec_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL retry_sub: got %b expected %b", o, e);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_unsat();
        apply_reset();
        drive_fork(0, 1'b0);
        exp_q.push_back(mk(1, 1'b0, 0, 1'b0));
        exp_q.push_back(mk(2, 1'b0, 1, 1'b0));
        exp_q.push_back(mk(2, 1'b0, 1, 1'b1));
        exp_q.push_back(mk(2, 1'b1, 1, 1'b0));
        exp_q.push_back(mk(1, 1'b1, 0, 1'b0));
        serve(8'b0000_1100, 400);
        checks++;
        if (!done || obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL unsat_count: got %0d done=%0d expected %0d done=1",
                     obs_q.size(), done, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            rec_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL unsat_sub: got %b expected %b", o, e);
            end
        end
        exp_q.delete();
        checks++;
        if ({unsat_cnt == 1, busy, sat_found, depth} !== 6'b100_000) begin
            failures++;
            $display("FAIL unsat_end_state: got pulses=%0d busy=%b sat=%b depth=%0d expected 1 0 0 0",
                     unsat_cnt, busy, sat_found, depth);
        end
        @(negedge clk);
        checks++;
        if ({unsat_pulse, bus.fork_in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL unsat_pulse_width_ready: got %b expected 01",
                     {unsat_pulse, bus.fork_in_ready});
        end
    endtask

    task automatic test_offload();
        apply_reset();
        bus.fork_out_ready = 1'b1;
        drive_fork(0, 1'b0);
        exp_q.push_back(mk(1, 1'b0, 0, 1'b0));
        exp_q.push_back(mk(2, 1'b0, 1, 1'b0));
        exp_q.push_back(mk(2, 1'b1, 1, 1'b0));
        exp_q.push_back(mk(1, 1'b1, 0, 1'b0));
        serve(8'b0000_0100, 400);
        bus.fork_out_ready = 1'b0;
        checks++;
        if (!done || obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL offload_count: got %0d done=%0d expected %0d done=1",
                     obs_q.size(), done, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            rec_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL offload_sub: got %b expected %b", o, e);
            end
        end
        exp_q.delete();
        checks++;
        if (fo_cnt !== 1 || fo_last !== 3'b011) begin
            failures++;
            $display("FAIL fork_out: got cycles=%0d rec=%b expected cycles=1 rec=011", fo_cnt, fo_last);
        end
        checks++;
        if (unsat_cnt !== 1) begin
            failures++;
            $display("FAIL offload_unsat: got %0d expected 1", unsat_cnt);
        end
    endtask

    task automatic test_last_var();
        apply_reset();
        drive_fork(NV - 1, 1'b1);
        exp_q.push_back(mk(1, 1'b0, NV - 1, 1'b1));
        serve(8'h00, 200);
        checks++;
        if (!done || obs_q.size() !== 1 || masks_total !== NC) begin
            failures++;
            $display("FAIL last_var_round: got subs=%0d masks=%0d done=%0d expected 1 %0d 1",
                     obs_q.size(), masks_total, done, NC);
        end
        if (obs_q.size() > 0) begin
            rec_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL last_var_sub: got %b expected %b", o, e);
            end
        end
        exp_q.delete();
        bus.fork_in_valid = 1'b1;
        bus.fork_in_var = 2'd0;
        repeat (3) @(negedge clk);
        bus.fork_in_valid = 1'b0;
        checks++;
        if ({sat_found, busy, bus.fork_in_ready, bus.sub_valid} !== 4'b1100) begin
            failures++;
            $display("FAIL last_var_terminal: got %b expected 1100",
                     {sat_found, busy, bus.fork_in_ready, bus.sub_valid});
        end
    endtask

    task automatic test_reset_mid_eval();
        apply_reset();
        drive_fork(0, 1'b0);
        bus.sub_ready = 1'b1;
        @(negedge clk);
        bus.sub_ready = 1'b0;
        bus.mask_valid = 1'b1;
        bus.mask = 3'b000;
        @(negedge clk);
        bus.mask_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, sat_found, unsat_pulse, bus.sub_valid, bus.fork_in_ready, depth} !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid_eval_outputs: got %b expected 00000000",
                     {busy, sat_found, unsat_pulse, bus.sub_valid, bus.fork_in_ready, depth});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.fork_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_eval_ready: got %b expected 1", bus.fork_in_ready);
        end
        drive_fork(NV - 1, 1'b0);
        exp_q.push_back(mk(1, 1'b0, NV - 1, 1'b0));
        serve(8'h00, 200);
        checks++;
        if (!done || obs_q.size() !== 1 || masks_total !== NC) begin
            failures++;
            $display("FAIL reset_mid_eval_round: got subs=%0d masks=%0d done=%0d expected 1 %0d 1",
                     obs_q.size(), masks_total, done, NC);
        end
        if (obs_q.size() > 0) begin
            rec_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_mid_eval_sub: got %b expected %b", o, e);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.fork_in_valid = 1'b0;
        bus.fork_in_var = '0;
        bus.fork_in_val = 1'b0;
        bus.sub_ready = 1'b0;
        bus.mask_valid = 1'b0;
        bus.mask = '0;
        bus.fork_out_ready = 1'b0;
        test_reset();
        test_sat_path();
        test_retry();
        test_unsat();
        test_offload();
        test_last_var();
        test_reset_mid_eval();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
